// File: rtl/regfile_wport_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | regfile_wport_arbiter_pkg : shared widths, constants and entry type         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package regfile_wport_arbiter_pkg;
  localparam int          c_reg_addr_bus_width = 5;
  localparam int          c_reg_data_bus_width = 32;
  localparam logic        c_enable_signal      = 1'b1;
  localparam logic        c_disable_signal     = 1'b0;
  localparam logic [31:0] c_zero_word          = 32'h0000_0000;
  localparam int          c_lu_fifo_depth      = 2;
  localparam int          c_starve_limit       = 4;

  typedef struct packed {
    logic [c_reg_addr_bus_width-1:0] addr;
    logic [c_reg_data_bus_width-1:0] data;
  } wport_entry_t;
endpackage
`default_nettype wire

// File: rtl/regfile_wport_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | regfile_wport_arbiter_if : writeback, LU, decode and regfile port bundle   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface regfile_wport_arbiter_if;
  import regfile_wport_arbiter_pkg::*;

  logic                            wb_we;
  logic [c_reg_addr_bus_width-1:0] wb_waddr;
  logic [c_reg_data_bus_width-1:0] wb_wdata;
  logic                            lu_issue;
  logic [c_reg_addr_bus_width-1:0] lu_issue_addr;
  logic                            lu_valid;
  logic                            lu_ready;
  logic [c_reg_addr_bus_width-1:0] lu_waddr;
  logic [c_reg_data_bus_width-1:0] lu_wdata;
  logic                            id_re1;
  logic                            id_re2;
  logic [c_reg_addr_bus_width-1:0] id_raddr1;
  logic [c_reg_addr_bus_width-1:0] id_raddr2;
  logic                            id_we;
  logic [c_reg_addr_bus_width-1:0] id_waddr;
  logic                            hazard;
  logic                            stall_req;
  logic                            rf_we;
  logic [c_reg_addr_bus_width-1:0] rf_waddr;
  logic [c_reg_data_bus_width-1:0] rf_wdata;

  modport master (
    output wb_we, wb_waddr, wb_wdata, lu_issue, lu_issue_addr,
    output lu_valid, lu_waddr, lu_wdata,
    output id_re1, id_re2, id_raddr1, id_raddr2, id_we, id_waddr,
    input  lu_ready, hazard, stall_req, rf_we, rf_waddr, rf_wdata
  );

  modport slave (
    input  wb_we, wb_waddr, wb_wdata, lu_issue, lu_issue_addr,
    input  lu_valid, lu_waddr, lu_wdata,
    input  id_re1, id_re2, id_raddr1, id_raddr2, id_we, id_waddr,
    output lu_ready, hazard, stall_req, rf_we, rf_waddr, rf_wdata
  );
endinterface
`default_nettype wire

// File: rtl/regfile_wport_arbiter_wport_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wport_fifo : synchronous FIFO of addr+data LU results, registered count    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module wport_fifo
  import regfile_wport_arbiter_pkg::*;
#(
  parameter int  DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  wire logic         clk,
  input  wire logic         rst,
  input  wire logic         push,
  input  wire wport_entry_t push_data,
  input  wire logic         pop,
  output wport_entry_t      head,
  output logic [CNT_W-1:0]  count
);
  wport_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr_ptr] <= push_data;
  end

  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;
endmodule
`default_nettype wire

// File: rtl/regfile_wport_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | regfile_wport_arbiter : shares the regfile write port between WB and LU    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module regfile_wport_arbiter
  import regfile_wport_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH   = c_lu_fifo_depth,
  parameter int STARVE_LIMIT = c_starve_limit
) (
  input wire logic               clk,
  input wire logic               rst,
  regfile_wport_arbiter_if.slave bus
);
  localparam int         CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  wport_entry_t     w_head;
  wport_entry_t     w_push_data;
  logic [CNT_W-1:0] w_count;
  logic             w_lu_ready;
  logic             w_push;
  logic             w_nonempty;
  logic             w_wb_own;
  logic             w_pop;
  logic             w_commit;
  logic [31:0]      r_pending;
  logic [31:0]      w_pending_nxt;
  logic [3:0]       r_wait_cnt;
  logic [3:0]       w_wait_nxt;
  logic             r_stall;
  logic             w_rd1_haz;
  logic             w_rd2_haz;
  logic             w_wr_haz;

  assign w_lu_ready  = !rst && (w_count < CNT_W'(FIFO_DEPTH));
  assign w_push      = bus.lu_valid && w_lu_ready;
  assign w_push_data = '{addr: bus.lu_waddr, data: bus.lu_wdata};
  assign w_nonempty  = (w_count != '0);
  assign w_wb_own    = bus.wb_we && (bus.wb_waddr != '0);
  assign w_pop       = !rst && !w_wb_own && w_nonempty;
  assign w_commit    = w_pop && (w_head.addr != '0);

  wport_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data (w_push_data),
    .pop       (w_pop),
    .head      (w_head),
    .count     (w_count)
  );

  // A zero-address LU result is popped with rf_we low so it only frees its slot.
  always_comb begin
    bus.rf_we    = c_disable_signal;
    bus.rf_waddr = '0;
    bus.rf_wdata = c_zero_word;
    if (!rst) begin
      if (w_wb_own) begin
        bus.rf_we    = c_enable_signal;
        bus.rf_waddr = bus.wb_waddr;
        bus.rf_wdata = bus.wb_wdata;
      end else if (w_nonempty) begin
        bus.rf_we    = (w_head.addr != '0);
        bus.rf_waddr = w_head.addr;
        bus.rf_wdata = w_head.data;
      end
    end
  end

  always_comb begin
    w_pending_nxt = r_pending;
    if (w_commit) w_pending_nxt[w_head.addr] = 1'b0;
    if (bus.lu_issue && (bus.lu_issue_addr != '0)) w_pending_nxt[bus.lu_issue_addr] = 1'b1;
    w_pending_nxt[0] = 1'b0;
  end

  always_comb begin
    w_wait_nxt = r_wait_cnt;
    if (!w_nonempty || w_pop)   w_wait_nxt = '0;
    else if (r_wait_cnt != 4'hF) w_wait_nxt = r_wait_cnt + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending  <= '0;
      r_wait_cnt <= '0;
      r_stall    <= 1'b0;
    end else begin
      r_pending  <= w_pending_nxt;
      r_wait_cnt <= w_wait_nxt;
      r_stall    <= (w_wait_nxt >= LIMIT);
    end
  end

  // Reads of the address being committed see the regfile bypass; WAW does not.
  assign w_rd1_haz = bus.id_re1 && r_pending[bus.id_raddr1] &&
                     !(w_commit && (w_head.addr == bus.id_raddr1));
  assign w_rd2_haz = bus.id_re2 && r_pending[bus.id_raddr2] &&
                     !(w_commit && (w_head.addr == bus.id_raddr2));
  assign w_wr_haz  = bus.id_we && r_pending[bus.id_waddr];

  assign bus.hazard    = !rst && (w_rd1_haz || w_rd2_haz || w_wr_haz);
  assign bus.stall_req = !rst && r_stall;
  assign bus.lu_ready  = w_lu_ready;
endmodule
`default_nettype wire
